controller_poller: RTL and testbench

CONTROLLER_POLLER -- requirements
Module: controller_poller

---
 rtl/ctrl_pkg.sv | 40 ++++
 rtl/ctrl_line_sync.sv | 27 ++
 rtl/controller_poller.sv | 186 ++++++++++++++++++
 tb/tb_controller_poller.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the controller poller: FSM states, poll command, reply field positions
// and the controller_out layout also consumed by the physics side.
package ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StTx,
      StRxWait,
      StRxBit,
      StCheck,
      StErr
   } ctrl_state_e;

   localparam logic [23:0] POLL_CMD  = 24'h400300;
   localparam int unsigned TX_CELLS  = 25;
   localparam int unsigned RESP_BITS = 64;

   // Reply bytes land MSB first in a 64-bit shift register: byte0 is bits 63:56.
   localparam int unsigned BYTE0_LSB = 56;
   localparam int unsigned BYTE1_LSB = 48;
   localparam int unsigned BYTE2_LSB = 40;
   localparam int unsigned BYTE3_LSB = 32;

   localparam int unsigned BTN_START  = 4;
   localparam int unsigned BTN_Y      = 3;
   localparam int unsigned BTN_X      = 2;
   localparam int unsigned BTN_B      = 1;
   localparam int unsigned BTN_A      = 0;
   localparam int unsigned HDR_LSB    = 5;
   localparam int unsigned ORIGIN_BIT = 7;

   localparam logic [31:0] NEUTRAL_WORD = 32'h0000_8080;

   localparam int unsigned OUT_START_BIT = 26;
   localparam int unsigned OUT_B_BIT     = 25;
   localparam int unsigned OUT_JUMP_BIT  = 24;
   localparam int unsigned OUT_X_LSB     = 8;
   localparam int unsigned OUT_Y_LSB     = 0;

endpackage

// File: rtl/ctrl_line_sync.sv
// Two-flop synchronizer for the open-drain data line plus a falling-edge detector on the
// synchronized value.
module ctrl_line_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic line_i,
   output logic line_o,
   output logic fall_o
);

   logic [1:0] sync_q;
   logic       prev_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= 2'b11;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], line_i};
         prev_q <= sync_q[1];
      end
   end

   assign line_o = sync_q[1];
   assign fall_o = prev_q & ~sync_q[1];

endmodule

// File: rtl/controller_poller.sv
// Periodically polls a single-wire game controller and publishes the decoded button/stick word.
// Optional macro CTRL_RUMBLE_EN takes the poll command LSB from the rumble input.
module controller_poller #(
   parameter int unsigned CLK_PER_US     = 50,
   parameter int unsigned POLL_PERIOD    = 833333,
   parameter int unsigned BIT_TIMEOUT_US = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        data_in,
   output logic        data_oe,
   input  logic        rumble,
   output logic [31:0] controller_out,
   output logic        sample_valid,
   output logic        connected
);
   import ctrl_pkg::*;

   localparam int unsigned CellCyc = 4 * CLK_PER_US;
   localparam int unsigned TmoCyc  = BIT_TIMEOUT_US * CLK_PER_US;
   localparam int unsigned CntMax  = (CellCyc > TmoCyc) ? CellCyc : TmoCyc;
   localparam int unsigned CntW    = $clog2(CntMax + 1);
   localparam int unsigned PollW   = $clog2(POLL_PERIOD + 1);

   localparam logic [CntW-1:0]  CellLast = CntW'(CellCyc - 1);
   localparam logic [CntW-1:0]  TmoLast  = CntW'(TmoCyc - 1);
   localparam logic [CntW-1:0]  SampleAt = CntW'(2 * CLK_PER_US - 1);
   localparam logic [CntW-1:0]  ShortCyc = CntW'(CLK_PER_US);
   localparam logic [CntW-1:0]  LongCyc  = CntW'(3 * CLK_PER_US);
   localparam logic [PollW-1:0] PollLast = PollW'(POLL_PERIOD - 1);
   localparam logic [6:0]       TxLast   = 7'(TX_CELLS - 1);
   localparam logic [6:0]       RespDone = 7'(RESP_BITS);

   ctrl_state_e      state_q, state_d;
   logic [PollW-1:0] poll_q, poll_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [6:0]       idx_q, idx_d;
   logic [63:0]      resp_q, resp_d;
   logic [31:0]      out_q, out_d;
   logic             valid_q, valid_d;
   logic             conn_q, conn_d;

   logic        line_sync, line_fall, poll_wrap, tx_bit, resp_ok, unused_resp;
   logic [23:0] tx_cmd;
   logic [24:0] tx_frame;
   logic [31:0] resp_word;

   ctrl_line_sync u_line_sync (
      .clk_i  (clock),
      .rst_i  (reset),
      .line_i (data_in),
      .line_o (line_sync),
      .fall_o (line_fall)
   );

   assign poll_wrap = (poll_q == PollLast);

`ifdef CTRL_RUMBLE_EN
   logic cmd_lsb_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cmd_lsb_q <= 1'b0;
      end else if (state_q == StIdle && poll_wrap) begin
         cmd_lsb_q <= rumble;
      end
   end

   assign tx_cmd = {POLL_CMD[23:1], cmd_lsb_q};
`else
   logic unused_rumble;
   assign unused_rumble = rumble;
   assign tx_cmd        = POLL_CMD;
`endif

   // Stop bit of value 1 follows the command, MSB first.
   assign tx_frame = {tx_cmd, 1'b1};
   assign tx_bit   = tx_frame[5'(TX_CELLS - 1) - idx_q[4:0]];
   assign data_oe  = (state_q == StTx) && (cnt_q < (tx_bit ? ShortCyc : LongCyc));

   always_comb begin
      resp_word                 = '0;
      resp_word[OUT_START_BIT]  = resp_q[BYTE0_LSB + BTN_START];
      resp_word[OUT_B_BIT]      = resp_q[BYTE0_LSB + BTN_B];
      resp_word[OUT_JUMP_BIT]   = resp_q[BYTE0_LSB + BTN_A] | resp_q[BYTE0_LSB + BTN_X];
      resp_word[OUT_X_LSB +: 8] = resp_q[BYTE2_LSB +: 8];
      resp_word[OUT_Y_LSB +: 8] = resp_q[BYTE3_LSB +: 8];
   end

   assign resp_ok = (resp_q[BYTE0_LSB + HDR_LSB +: 3] == 3'b000) &&
                    resp_q[BYTE1_LSB + ORIGIN_BIT];
   assign unused_resp = ^{resp_q[BYTE0_LSB + BTN_Y], resp_q[BYTE1_LSB +: 7],
                          resp_q[BYTE3_LSB-1:0]};

   always_comb begin
      state_d = state_q;
      poll_d  = poll_wrap ? '0 : poll_q + PollW'(1);
      cnt_d   = '0;
      idx_d   = idx_q;
      resp_d  = resp_q;
      out_d   = out_q;
      valid_d = 1'b0;
      conn_d  = conn_q;
      unique case (state_q)
         StIdle: begin
            if (poll_wrap) begin
               state_d = StTx;
               idx_d   = '0;
            end
         end
         StTx: begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CellLast) begin
               cnt_d = '0;
               if (idx_q == TxLast) begin
                  state_d = StRxWait;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 7'd1;
               end
            end
         end
         StRxWait: begin
            cnt_d = cnt_q + CntW'(1);
            if (line_fall) begin
               cnt_d   = '0;
               state_d = (idx_q == RespDone) ? StCheck : StRxBit;
            end else if (cnt_q == TmoLast) begin
               state_d = StErr;
            end
         end
         StRxBit: begin
            // Edges before the sample point are ignored; only the counter advances.
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == SampleAt) begin
               cnt_d   = '0;
               resp_d  = {resp_q[62:0], line_sync};
               idx_d   = idx_q + 7'd1;
               state_d = StRxWait;
            end
         end
         StCheck: begin
            if (resp_ok) begin
               out_d   = resp_word;
               valid_d = 1'b1;
               conn_d  = 1'b1;
               state_d = StIdle;
            end else begin
               state_d = StErr;
            end
         end
         StErr: begin
            conn_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         poll_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         resp_q  <= '0;
         out_q   <= NEUTRAL_WORD;
         valid_q <= 1'b0;
         conn_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         poll_q  <= poll_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         resp_q  <= resp_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         conn_q  <= conn_d;
      end
   end

   assign controller_out = out_q;
   assign sample_valid   = valid_q;
   assign connected      = conn_q;

endmodule

// File: tb/tb_controller_poller.sv
// Self-checking bench for controller_poller: an open-drain line model plays the controller and a
// spec-level model predicts controller_out, connected and sample_valid for each poll.
module tb_controller_poller;

   localparam int unsigned CPU    = 8;
   localparam int unsigned PP     = 4000;
   localparam int unsigned TMO_US = 10;
   localparam int          CELL   = 4 * CPU;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        rumble = 1'b0;
   logic        dev_pull = 1'b0;
   logic        data_in, data_oe, sample_valid, connected;
   logic [31:0] controller_out;

   int          total = 0;
   int          bad = 0;
   int          valid_cnt = 0;
   logic [31:0] exp_out;
   logic        exp_conn;

   assign data_in = ~(data_oe | dev_pull);

   controller_poller #(
      .CLK_PER_US     (CPU),
      .POLL_PERIOD    (PP),
      .BIT_TIMEOUT_US (TMO_US)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .data_in        (data_in),
      .data_oe        (data_oe),
      .rumble         (rumble),
      .controller_out (controller_out),
      .sample_valid   (sample_valid),
      .connected      (connected)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (sample_valid === 1'b1) valid_cnt++;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog expired");
   end

   // Reference: a good reply updates the word, anything else only drops connected.
   task automatic model_frame(input logic [63:0] r, input bit silent, output int pulses);
      logic [7:0] b0, b1, b2, b3;
      b0 = r[63:56];
      b1 = r[55:48];
      b2 = r[47:40];
      b3 = r[39:32];
      pulses = 0;
      if (silent || (b0 >> 5) != 8'd0 || (b1 & 8'h80) == 8'd0) begin
         exp_conn = 1'b0;
      end else begin
         exp_out  = {5'b0, b0[4], b0[1], b0[0] | b0[2], 8'h00, b2, b3};
         exp_conn = 1'b1;
         pulses   = 1;
      end
   endtask

   task automatic wait_rise(output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (n < int'(PP) + 20) begin
         @(posedge clock);
         n++;
         @(negedge clock);
         if (data_oe === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic skip_tx();
      repeat (25 * CELL - 1) @(negedge clock);
   endtask

   task automatic respond(input logic [63:0] r, input bit silent);
      bit b;
      repeat (2 * CPU) @(negedge clock);
      if (!silent) begin
         for (int k = 0; k < 65; k++) begin
            b = (k < 64) ? r[63-k] : 1'b1;
            dev_pull = 1'b1;
            repeat (b ? CPU : 3 * CPU) @(negedge clock);
            dev_pull = 1'b0;
            repeat (b ? 3 * CPU : CPU) @(negedge clock);
         end
      end
      repeat (TMO_US * CPU + 20) @(negedge clock);
   endtask

   task automatic poll_frame(input string name, input logic [63:0] r, input bit silent);
      int n, v0, pulses;
      bit ok;
      wait_rise(n, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s_poll_start: no data_oe rise in %0d cycles, required one", name, n);
         return;
      end
      skip_tx();
      v0 = valid_cnt;
      respond(r, silent);
      model_frame(r, silent, pulses);
      total++;
      if (controller_out !== exp_out) begin
         bad++;
         $display("FAIL %s_out: got %h, required %h", name, controller_out, exp_out);
      end
      total++;
      if (connected !== exp_conn) begin
         bad++;
         $display("FAIL %s_connected: got %b, required %b", name, connected, exp_conn);
      end
      total++;
      if (valid_cnt - v0 != pulses) begin
         bad++;
         $display("FAIL %s_valid: got %0d pulses, required %0d", name, valid_cnt - v0, pulses);
      end
   endtask

   task automatic test_reset();
      int  n;
      bit  ok;
      reset = 1'b0;
      #1;
      total++;
      if (controller_out !== 32'h0000_8080 || connected !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: out=%h conn=%b, required 00008080/0", controller_out,
                  connected);
      end
      total++;
      if (data_oe !== 1'b0 || sample_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_drive: oe=%b valid=%b, required 0/0", data_oe, sample_valid);
      end
      wait_rise(n, ok);
      total++;
      if (!ok || n != int'(PP)) begin
         bad++;
         $display("FAIL reset_first_poll: rise at cycle %0d, required %0d", n, PP);
      end
   endtask

   // Continues from the first data_oe sample of the poll found by test_reset.
   task automatic test_tx_frame();
      logic [24:0] frame;
      logic        cmd_lsb;
      int          hi, want, first_lo, v0, pulses;
      bit          contig;
`ifdef CTRL_RUMBLE_EN
      cmd_lsb = rumble;
`else
      cmd_lsb = 1'b0;
`endif
      frame = {24'h400300 | {23'b0, cmd_lsb}, 1'b1};
      for (int c = 0; c < 25; c++) begin
         hi       = 0;
         first_lo = -1;
         contig   = 1'b1;
         want     = frame[24-c] ? int'(CPU) : int'(3 * CPU);
         for (int k = 0; k < CELL; k++) begin
            if (!(c == 0 && k == 0)) @(negedge clock);
            if (c == 12 && k == 0) rumble = ~rumble;
            if (data_oe === 1'b1) begin
               hi++;
               if (first_lo >= 0) contig = 1'b0;
            end else if (first_lo < 0) begin
               first_lo = k;
            end
         end
         total++;
         if (hi != want || !contig || first_lo < 0) begin
            bad++;
            $display("FAIL tx_cell%0d: high=%0d contiguous=%0d, required high=%0d contiguous=1",
                     c, hi, contig, want);
         end
      end
      @(negedge clock);
      total++;
      if (data_oe !== 1'b0) begin
         bad++;
         $display("FAIL tx_release: data_oe=%b after stop cell, required 0", data_oe);
      end
      v0 = valid_cnt;
      respond(64'h0, 1'b1);
      model_frame(64'h0, 1'b1, pulses);
      total++;
      if (connected !== exp_conn || valid_cnt - v0 != pulses) begin
         bad++;
         $display("FAIL tx_tail: conn=%b pulses=%0d, required %b/%0d", connected,
                  valid_cnt - v0, exp_conn, pulses);
      end
   endtask

   task automatic test_good_response();
      logic [63:0] r;
      r = {32'h1180_C020, $urandom()};
      poll_frame("good", r, 1'b0);
      total++;
      if (controller_out !== 32'h0500_C020) begin
         bad++;
         $display("FAIL good_word: got %h, required 0500c020", controller_out);
      end
   endtask

   task automatic test_silent();
      poll_frame("silent", 64'h0, 1'b1);
   endtask

   task automatic test_bad_byte1();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      r[63:61] = 3'b000;
      r[55]    = 1'b0;
      poll_frame("bad_byte1", r, 1'b0);
   endtask

   task automatic test_random();
      logic [63:0] r;
      for (int i = 0; i < 5; i++) begin
         r = {$urandom(), $urandom()};
         if ($urandom_range(0, 3) != 0) r[63:61] = 3'b000;
         if ($urandom_range(0, 3) != 0) r[55] = 1'b1;
         poll_frame("random", r, 1'b0);
      end
   endtask

   task automatic test_midframe_reset();
      logic [63:0] r;
      int          n;
      bit          ok;
      r = {8'h15, 8'hFF, 8'h3C, 8'hA7, $urandom()};
      poll_frame("pre_reset", r, 1'b0);
      wait_rise(n, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL midreset_poll_start: no data_oe rise in %0d cycles, required one", n);
         return;
      end
      repeat ($urandom_range(10, 25 * CELL + TMO_US * CPU - 10)) @(negedge clock);
      reset = 1'b1;
      #1;
      exp_out  = 32'h0000_8080;
      exp_conn = 1'b0;
      total++;
      if (data_oe !== 1'b0 || controller_out !== exp_out || connected !== exp_conn) begin
         bad++;
         $display("FAIL midreset_abort: oe=%b out=%h conn=%b, required 0/%h/%b", data_oe,
                  controller_out, connected, exp_out, exp_conn);
      end
      repeat (2) @(negedge clock);
      reset = 1'b0;
      wait_rise(n, ok);
      total++;
      if (!ok || n != int'(PP)) begin
         bad++;
         $display("FAIL midreset_next_poll: rise at cycle %0d, required %0d", n, PP);
      end
   endtask

   initial begin
      rumble   = 1'($urandom_range(0, 1));
      exp_out  = 32'h0000_8080;
      exp_conn = 1'b0;
      repeat (3) @(negedge clock);
      test_reset();
      test_tx_frame();
      test_good_response();
      test_silent();
      test_bad_byte1();
      test_random();
      test_midframe_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
